multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 260 ++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory wait timeout and sticky trap state.
//
// Ports:
//   clk, rst             clock, async active-high reset
//   instr                instruction word, sampled when ir_en=1
//   rs1_data, rs2_data   operands for branch compare
//   mem_ready            memory completes current request
//   mem_req/mem_we/adr_src        memory request, write, address select
//   ir_en/pc_en/reg_write         datapath write enables
//   alu_src_a/alu_src_b/alu_op    ALU operand selects and operation
//   imm_src/result_src/pc_src     immediate, writeback, PC selects
//   busy/fault/state_o            status and current state
module multicycle_control_unit #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic            adr_src,
  output logic            ir_en,
  output logic            pc_en,
  output logic            reg_write,
  output logic [1:0]      alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [3:0]      alu_op,
  output logic [2:0]      imm_src,
  output logic [1:0]      result_src,
  output logic [1:0]      pc_src,
  output logic            busy,
  output logic            fault,
  output logic [3:0]      state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_MEM   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        started_q;
  logic [15:0] wait_q;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic        f7_q;

  logic mem_wait, timeout;
  logic eq, lt_s, lt_u, br_taken, br_bad;

  logic unused_instr;
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  function automatic logic [3:0] alu_dec(
    input logic [2:0] f3,
    input logic       sub,
    input logic       sra
  );
    case (f3)
      3'b000:  return sub ? 4'd1 : 4'd0;
      3'b001:  return 4'd5;
      3'b010:  return 4'd8;
      3'b011:  return 4'd9;
      3'b100:  return 4'd4;
      3'b101:  return sra ? 4'd7 : 4'd6;
      3'b110:  return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // FETCH only counts as a memory wait once the post-reset
  // request has actually been issued.
  assign mem_wait = (state_q == S_FETCH && started_q)
                 || state_q == S_MEM_RD
                 || state_q == S_MEM_WR;
  assign timeout  = mem_wait && !mem_ready
                 && wait_q == WAIT_LAST;

  assign eq   = rs1_data == rs2_data;
  assign lt_s = $signed(rs1_data) < $signed(rs2_data);
  assign lt_u = rs1_data < rs2_data;

  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (funct3_q)
      3'b000:  br_taken = eq;
      3'b001:  br_taken = !eq;
      3'b100:  br_taken = lt_s;
      3'b101:  br_taken = !lt_s;
      3'b110:  br_taken = lt_u;
      3'b111:  br_taken = !lt_u;
      default: br_bad   = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      started_q <= 1'b0;
      wait_q    <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      f7_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= 1'b1;
      if (state_d != state_q)
        wait_q <= '0;
      else if (mem_wait && !mem_ready)
        wait_q <= wait_q + 16'd1;
      if (ir_en) begin
        opcode_q <= instr[6:0];
        funct3_q <= instr[14:12];
        f7_q     <= instr[30];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'd0;
    alu_src_b  = 2'd0;
    alu_op     = 4'd0;
    imm_src    = 3'd0;
    result_src = 2'd0;
    pc_src     = 2'd0;
    fault      = 1'b0;
    busy       = state_q != S_FETCH && state_q != S_TRAP;
    case (state_q)
      S_FETCH: begin
        if (started_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_en   = 1'b1;
            pc_en   = 1'b1;
            busy    = 1'b1;
            state_d = S_DECODE;
          end else if (timeout) begin
            state_d = S_TRAP;
          end
        end
      end
      S_DECODE: begin
        case (opcode_q)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BR:             state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        alu_op  = alu_dec(funct3_q, f7_q, f7_q);
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_b = 2'd1;
        alu_op    = alu_dec(funct3_q, 1'b0, f7_q);
        state_d   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_b = 2'd1;
        if (opcode_q == OP_STORE) begin
          imm_src = 3'd1;
          state_d = S_MEM_WR;
        end else begin
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD, S_MEM_WR: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        mem_we  = state_q == S_MEM_WR;
        if (mem_ready)
          state_d = (state_q == S_MEM_WR) ? S_FETCH : S_WB_MEM;
        else if (timeout)
          state_d = S_TRAP;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        result_src = 2'd1;
        state_d    = S_FETCH;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
        imm_src   = 3'd2;
        pc_src    = 2'd1;
        pc_en     = br_taken;
        state_d   = br_bad ? S_TRAP : S_FETCH;
      end
      S_JAL, S_JALR: begin
        alu_src_a  = (state_q == S_JAL) ? 2'd1 : 2'd0;
        alu_src_b  = 2'd1;
        imm_src    = (state_q == S_JAL) ? 3'd4 : 3'd0;
        reg_write  = 1'b1;
        result_src = 2'd2;
        pc_en      = 1'b1;
        pc_src     = 2'd1;
        state_d    = S_FETCH;
      end
      S_UPPER: begin
        alu_src_a = (opcode_q == OP_LUI) ? 2'd2 : 2'd1;
        alu_src_b = 2'd1;
        imm_src   = 3'd3;
        state_d   = S_WB_ALU;
      end
      S_TRAP: begin
        fault = 1'b1;
      end
      default: state_d = S_TRAP;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: per-instruction cycle
// expectations from an ISA-level model, checked by a negedge monitor.
module tb_multicycle_control_unit;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DEC    = 4'd1;
  localparam logic [3:0] ST_EXR    = 4'd2;
  localparam logic [3:0] ST_EXI    = 4'd3;
  localparam logic [3:0] ST_MADDR  = 4'd4;
  localparam logic [3:0] ST_MRD    = 4'd5;
  localparam logic [3:0] ST_MWR    = 4'd6;
  localparam logic [3:0] ST_WBM    = 4'd7;
  localparam logic [3:0] ST_WBA    = 4'd8;
  localparam logic [3:0] ST_BR     = 4'd9;
  localparam logic [3:0] ST_JAL    = 4'd10;
  localparam logic [3:0] ST_JALR   = 4'd11;
  localparam logic [3:0] ST_UPPER  = 4'd12;
  localparam logic [3:0] ST_TRAP   = 4'd15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     instr = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic            mem_ready = 1'b0;
  logic            mem_req, mem_we, adr_src;
  logic            ir_en, pc_en, reg_write;
  logic [1:0]      alu_src_a, alu_src_b;
  logic [3:0]      alu_op;
  logic [2:0]      imm_src;
  logic [1:0]      result_src, pc_src;
  logic            busy, fault;
  logic [3:0]      state_o;

  multicycle_control_unit #(
    .XLEN(XLEN), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .adr_src(adr_src),
    .ir_en(ir_en), .pc_en(pc_en),
    .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .result_src(result_src),
    .pc_src(pc_src), .busy(busy), .fault(fault),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_we, adr_src;
    logic       ir_en, pc_en, reg_write;
    logic [1:0] pc_src, result_src, src_a, src_b;
    logic [3:0] alu_op;
    logic [2:0] imm_src;
    logic       busy, fault;
  } ctl_t;

  typedef struct {
    ctl_t v;
    ctl_t m;
  } exp_t;

  exp_t sb[$];
  bit   rdy_plan[$];
  ctl_t cur_v, cur_m;
  int   total = 0;
  int   bad = 0;

  function automatic ctl_t obs();
    ctl_t o;
    o.st = state_o;
    o.mem_req = mem_req;
    o.mem_we = mem_we;
    o.adr_src = adr_src;
    o.ir_en = ir_en;
    o.pc_en = pc_en;
    o.reg_write = reg_write;
    o.pc_src = pc_src;
    o.result_src = result_src;
    o.src_a = alu_src_a;
    o.src_b = alu_src_b;
    o.alu_op = alu_op;
    o.imm_src = imm_src;
    o.busy = busy;
    o.fault = fault;
    return o;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every active cycle with a pending expectation is compared.
  exp_t e_mon;
  logic [$bits(ctl_t)-1:0] ov, ev, mv;
  always @(negedge clk) begin
    if (!rst && sb.size() > 0) begin
      e_mon = sb.pop_front();
      ov = obs();
      ev = e_mon.v;
      mv = e_mon.m;
      total++;
      if ((ov & mv) !== (ev & mv)) begin
        bad++;
        $display("FAIL cycle st=%0d: got %h expected %h mask %h",
                 e_mon.v.st, ov, ev, mv);
      end
    end
  end

  // ALU operation implied by an OP / OP-IMM funct3 (RV32I base ISA).
  function automatic logic [3:0] alu_ref(input logic [2:0] f3,
                                         input bit is_reg,
                                         input bit alt);
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd4, 4'd6, 4'd3, 4'd2};
    if (f3 == 3'd0 && is_reg && alt) return 4'd1;
    if (f3 == 3'd5 && alt) return 4'd7;
    return tbl[f3];
  endfunction

  task automatic cyc(input logic [3:0] st);
    cur_v = '0;
    cur_m = '0;
    cur_v.st = st;
    cur_m.st = '1;
    cur_m.mem_req = 1'b1;
    cur_m.mem_we = 1'b1;
    cur_m.ir_en = 1'b1;
    cur_m.pc_en = 1'b1;
    cur_m.reg_write = 1'b1;
    cur_m.busy = 1'b1;
    cur_m.fault = 1'b1;
    cur_v.busy = (st != ST_FETCH && st != ST_TRAP);
    cur_v.fault = (st == ST_TRAP);
  endtask

  task automatic put(input bit r);
    exp_t e;
    e.v = cur_v;
    e.m = cur_m;
    sb.push_back(e);
    rdy_plan.push_back(r);
  endtask

  task automatic put_rnd();
    put(1'($urandom_range(0, 1)));
  endtask

  task automatic mem_wait(input logic [3:0] st, input bit we,
                          input int lat, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < TO && !ok; k++) begin
      cyc(st);
      cur_v.mem_req = 1'b1;
      cur_v.mem_we = we;
      cur_v.adr_src = (st != ST_FETCH);
      cur_m.adr_src = 1'b1;
      if (k == lat) begin
        if (st == ST_FETCH) begin
          cur_v.ir_en = 1'b1;
          cur_v.pc_en = 1'b1;
          cur_v.busy = 1'b1;
          cur_m.pc_src = '1;
        end
        put(1'b1);
        ok = 1'b1;
      end else begin
        put(1'b0);
      end
    end
  endtask

  task automatic trap_tail();
    for (int k = 0; k < 3; k++) begin
      cyc(ST_TRAP);
      put_rnd();
    end
  endtask

  task automatic wb(input logic [1:0] rs);
    cyc(rs == 2'd1 ? ST_WBM : ST_WBA);
    cur_v.reg_write = 1'b1;
    cur_v.result_src = rs;
    cur_m.result_src = '1;
    put_rnd();
  endtask

  task automatic plan_instr(input logic [31:0] ins,
                            input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b,
                            input int lf, input int lm,
                            output bit trapped);
    bit ok, tk;
    logic [6:0] op;
    logic [2:0] f3;
    logic alt;
    op = ins[6:0];
    f3 = ins[14:12];
    alt = ins[30];
    trapped = 1'b0;
    mem_wait(ST_FETCH, 1'b0, lf, ok);
    if (!ok) begin
      trap_tail();
      trapped = 1'b1;
      return;
    end
    cyc(ST_DEC);
    put_rnd();
    case (op)
      7'b0110011, 7'b0010011: begin
        cyc(op[5] ? ST_EXR : ST_EXI);
        cur_v.alu_op = alu_ref(f3, op[5], alt);
        cur_m.alu_op = '1;
        put_rnd();
        wb(2'd0);
      end
      7'b0000011, 7'b0100011: begin
        cyc(ST_MADDR);
        cur_v.imm_src = op[5] ? 3'd1 : 3'd0;
        cur_v.src_b = 2'd1;
        cur_m.imm_src = '1;
        cur_m.src_a = '1;
        cur_m.src_b = '1;
        cur_m.alu_op = '1;
        put_rnd();
        mem_wait(op[5] ? ST_MWR : ST_MRD, op[5], lm, ok);
        if (!ok) begin
          trap_tail();
          trapped = 1'b1;
        end else if (!op[5]) begin
          wb(2'd1);
        end
      end
      7'b1100011: begin
        case (f3)
          3'd0:    tk = (a == b);
          3'd1:    tk = (a != b);
          3'd4:    tk = ($signed(a) < $signed(b));
          3'd5:    tk = !($signed(a) < $signed(b));
          3'd6:    tk = (a < b);
          default: tk = !(a < b);
        endcase
        cyc(ST_BR);
        if (f3 == 3'd2 || f3 == 3'd3) begin
          put_rnd();
          trap_tail();
          trapped = 1'b1;
        end else begin
          cur_v.pc_en = tk;
          if (tk) begin
            cur_v.pc_src = 2'd1;
            cur_v.src_a = 2'd1;
            cur_v.src_b = 2'd1;
            cur_v.imm_src = 3'd2;
            cur_m.pc_src = '1;
            cur_m.src_a = '1;
            cur_m.src_b = '1;
            cur_m.imm_src = '1;
          end
          put_rnd();
        end
      end
      7'b1101111, 7'b1100111: begin
        cyc(op[3] ? ST_JAL : ST_JALR);
        cur_v.reg_write = 1'b1;
        cur_v.pc_en = 1'b1;
        cur_v.result_src = 2'd2;
        cur_v.pc_src = 2'd1;
        cur_v.src_a = op[3] ? 2'd1 : 2'd0;
        cur_v.src_b = 2'd1;
        cur_v.imm_src = op[3] ? 3'd4 : 3'd0;
        cur_m.result_src = '1;
        cur_m.pc_src = '1;
        cur_m.src_a = '1;
        cur_m.src_b = '1;
        cur_m.imm_src = '1;
        put_rnd();
      end
      7'b0110111, 7'b0010111: begin
        cyc(ST_UPPER);
        cur_v.src_a = op[5] ? 2'd2 : 2'd1;
        cur_v.src_b = 2'd1;
        cur_v.imm_src = 3'd3;
        cur_m.src_a = '1;
        cur_m.src_b = '1;
        cur_m.imm_src = '1;
        put_rnd();
        wb(2'd0);
      end
      default: begin
        trap_tail();
        trapped = 1'b1;
      end
    endcase
  endtask

  task automatic drive();
    while (rdy_plan.size() > 0) begin
      mem_ready = rdy_plan.pop_front();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(ST_FETCH);
    cur_m = '1;
    put(1'b0);
    drive();
  endtask

  task automatic run(input logic [31:0] ins,
                     input logic [XLEN-1:0] a,
                     input logic [XLEN-1:0] b,
                     input int lf, input int lm);
    bit t;
    plan_instr(ins, a, b, lf, lm, t);
    instr = ins;
    rs1_data = a;
    rs2_data = b;
    drive();
    if (t) do_reset();
  endtask

  function automatic bit known_op(input logic [6:0] op);
    return op inside {7'b0110011, 7'b0010011, 7'b0000011,
                      7'b0100011, 7'b1100011, 7'b1101111,
                      7'b1100111, 7'b0110111, 7'b0010111};
  endfunction

  initial begin
    ctl_t r;
    bit t;
    logic [6:0] ops [9];
    logic [6:0] op;
    logic [31:0] ins;
    logic [XLEN-1:0] a, b;
    int lf, lm;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111};
    #1;
    r = obs();
    chk("reset_outputs", {5'd0, r}, 32'd0);
    do_reset();

    run(32'h002081B3, 32'd7, 32'd9, 0, 0);
    run(32'h0000A283, 32'd0, 32'd0, 0, 3);
    run(32'h00208063, 32'h5, 32'h5, 0, 0);
    run(32'h0020E063, 32'hFFFF_FFFF, 32'h1, 1, 0);
    run(32'h0000007F, 32'd0, 32'd0, 0, 0);
    run(32'h002081B3, 32'd1, 32'd2, 99, 0);
    run(32'h002081B3, 32'd1, 32'd2, TO - 1, 0);
    run(32'h4020D1B3, 32'd1, 32'd2, 0, 0);
    run(32'h0000A283, 32'd0, 32'd0, 0, 99);

    // Reset while a store is still waiting on memory.
    plan_instr(32'h0020A023, 32'd0, 32'd0, 0, 2, t);
    void'(rdy_plan.pop_back());
    void'(sb.pop_back());
    instr = 32'h0020A023;
    drive();
    mem_ready = 1'b0;
    chk("mwr_state", {28'd0, state_o}, {28'd0, ST_MWR});
    chk("mwr_req", {31'd0, mem_req}, 32'd1);
    chk("mwr_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_state", {28'd0, state_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    do_reset();

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        op = 7'h7F;
        for (int k = 0; k < 20; k++) begin
          op = 7'($urandom);
          if (!known_op(op)) break;
        end
        if (known_op(op)) op = 7'h7F;
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      ins = $urandom;
      ins[6:0] = op;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : XLEN'($urandom);
      lf = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 2)
                                       : $urandom_range(0, TO - 1);
      lm = ($urandom_range(0, 9) == 0) ? $urandom_range(TO, TO + 2)
                                       : $urandom_range(0, TO - 1);
      run(ins, a, b, lf, lm);
    end

    @(negedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
